multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 CLK  input  1  rising-edge clock; the block SHALL have this one clock only.
REQ-003 Reset  input  1  reset; synchronous, active-high.
REQ-004 Opcode  input  11  instruction bits [31:21] from the instruction register.
REQ-005 Zero  input  1  ALU zero flag, sampled in EXEC.
REQ-006 MemReady  input  1  memory handshake; high = access completes this cycle.
REQ-007 SignOp  output  3  sign-extender control: I=000, D=001, B=010, CB=011, IW=100.
REQ-008 Reg2Loc, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, IRWrite, PCWrite, PCSrc  outputs  1 each  datapath strobes.
REQ-009 ALUOp  output  4  ALU operation select.
REQ-010 Illegal  output  1  sticky undecodable-opcode flag.
REQ-011 InstrCount  output  CNT_W  retired-instruction counter.

Function
REQ-012 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-013 FETCH SHALL assert MemRead and IRWrite, and SHALL hold while MemReady=0; it SHALL go to DECODE on the cycle MemReady=1.
REQ-014 DECODE SHALL classify Opcode and drive SignOp for the class, holding it through EXEC and MEM of the same instruction.
  - R-type: ADD/SUB/AND/ORR.
  - I (SignOp 000): ADDI/SUBI.
  - D (001): LDUR/STUR.
  - B (010): opcode 000101xxxxx.
  - CB (011): CBZ, 10110100xxx.
  - IW (100): MOVZ, 110100101xx.
REQ-015 An unmatched Opcode in DECODE SHALL go to TRAP, set Illegal, deassert all strobes and stay in TRAP until Reset.
REQ-016 Total latency per instruction class, in cycles with MemReady=1:
  - R/I/IW: 4 (F,D,E,WB).
  - LDUR: 5 (F,D,E,M,WB).
  - STUR: 4 (F,D,E,M).
  - B/CB: 3 (F,D,E).
REQ-017 MEM SHALL assert MemRead (LDUR) or MemWrite (STUR), and SHALL hold while MemReady=0.
REQ-018 WB SHALL assert RegWrite for exactly one cycle; MemToReg=1 only for LDUR.
REQ-019 In EXEC, B SHALL assert PCWrite and PCSrc; CBZ SHALL assert PCWrite, with PCSrc=Zero.
REQ-020 For non-branch instructions, PCWrite SHALL pulse in the final state of the instruction.
REQ-021 Reg2Loc SHALL be 1 for STUR and CBZ; ALUSrc SHALL be 1 for I, D and IW.
REQ-022 InstrCount SHALL increment by 1 in the final cycle of each completed instruction and SHALL wrap modulo 2^CNT_W; TRAP SHALL NOT increment it.
REQ-023 All strobes not listed for a state SHALL be 0 in that state.

Reset
REQ-024 With Reset=1 at a clock edge, the next state SHALL be FETCH, whatever the current state, including TRAP or a stalled MEM.
REQ-025 Reset values: SignOp=000, ALUOp=0, Illegal=0, InstrCount=0, and all strobes 0 during the Reset cycle.

Configuration
REQ-026 With MOVZ_EN defined, MOVZ SHALL decode as IW (SignOp=100, 4 cycles).
REQ-027 Without MOVZ_EN, MOVZ SHALL be treated as illegal (TRAP), and SignOp SHALL never take the value 100.

Structure
REQ-028 A shared package SHALL hold the SignOp encodings, state encodings, ALUOp encodings and opcode match constants.
REQ-029 The opcode classifier SHALL be one combinational sub-module, opcode_decode.

Verification
REQ-030 ADD (10001011000), MemReady=1 -> states F,D,E,WB; RegWrite high in cycle 4 only; InstrCount 0->1.
REQ-031 LDUR with MemReady=0 for 3 cycles in MEM -> MemRead held 3 extra cycles; SignOp=001 throughout; MemToReg=1 in WB; 8 cycles total.
REQ-032 CBZ with Zero=1 -> SignOp=011, PCWrite=1 and PCSrc=1 in cycle 3; with Zero=0 -> PCSrc=0; RegWrite never high.
REQ-033 MOVZ (11010010100) -> with MOVZ_EN: SignOp=100, 4 cycles; without it: Illegal=1, TRAP, InstrCount unchanged.
REQ-034 Opcode 00000000000 -> TRAP; later Reset=1 -> FETCH, Illegal=0, InstrCount=0.
REQ-035 InstrCount preloaded to all ones (force, CNT_W=4) plus one ADD -> InstrCount wraps to 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle LEGv8 control unit: FSM states,
// instruction classes, SignOp/ALUOp codes and opcode match constants.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_LD  = 3'd2,
        CLS_ST  = 3'd3,
        CLS_B   = 3'd4,
        CLS_CB  = 3'd5,
        CLS_IW  = 3'd6,
        CLS_ILL = 3'd7
    } instr_class_e;

    localparam logic [2:0] SIGN_I  = 3'b000;
    localparam logic [2:0] SIGN_D  = 3'b001;
    localparam logic [2:0] SIGN_B  = 3'b010;
    localparam logic [2:0] SIGN_CB = 3'b011;
    localparam logic [2:0] SIGN_IW = 3'b100;

    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_ORR    = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_PASS_B = 4'b0111;

    // Opcode values with the don't-care bits cleared; masks mark the bits compared.
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_SUBI = 11'b11010001000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_MOVZ = 11'b11010010100;

    localparam logic [10:0] MASK_FULL = 11'b11111111111;
    localparam logic [10:0] MASK_IMM  = 11'b11111111110;
    localparam logic [10:0] MASK_B    = 11'b11111100000;
    localparam logic [10:0] MASK_CBZ  = 11'b11111111000;
    localparam logic [10:0] MASK_MOVZ = 11'b11111111100;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] val,
                                      input logic [10:0] mask);
        return ((op & mask) == (val & mask));
    endfunction

endpackage

// File: rtl/multicycle_control_opcode_decode.sv
// Combinational opcode classifier. MOVZ_EN enables MOVZ as an IW-class
// instruction; without it MOVZ falls through to the illegal class.
module opcode_decode
    import multicycle_control_pkg::*;
(
    input  logic [10:0] opcode,
    output logic [2:0]  cls,
    output logic [2:0]  sign_op,
    output logic [3:0]  alu_op
);

    // Priority match of the opcode against every supported encoding.
    always_comb begin
        cls     = CLS_ILL;
        sign_op = SIGN_I;
        alu_op  = ALU_AND;
        if (op_match(opcode, OP_ADD, MASK_FULL)) begin
            cls    = CLS_R;
            alu_op = ALU_ADD;
        end else if (op_match(opcode, OP_SUB, MASK_FULL)) begin
            cls    = CLS_R;
            alu_op = ALU_SUB;
        end else if (op_match(opcode, OP_AND, MASK_FULL)) begin
            cls    = CLS_R;
            alu_op = ALU_AND;
        end else if (op_match(opcode, OP_ORR, MASK_FULL)) begin
            cls    = CLS_R;
            alu_op = ALU_ORR;
        end else if (op_match(opcode, OP_ADDI, MASK_IMM)) begin
            cls     = CLS_I;
            sign_op = SIGN_I;
            alu_op  = ALU_ADD;
        end else if (op_match(opcode, OP_SUBI, MASK_IMM)) begin
            cls     = CLS_I;
            sign_op = SIGN_I;
            alu_op  = ALU_SUB;
        end else if (op_match(opcode, OP_LDUR, MASK_FULL)) begin
            cls     = CLS_LD;
            sign_op = SIGN_D;
            alu_op  = ALU_ADD;
        end else if (op_match(opcode, OP_STUR, MASK_FULL)) begin
            cls     = CLS_ST;
            sign_op = SIGN_D;
            alu_op  = ALU_ADD;
        end else if (op_match(opcode, OP_B, MASK_B)) begin
            cls     = CLS_B;
            sign_op = SIGN_B;
            alu_op  = ALU_AND;
        end else if (op_match(opcode, OP_CBZ, MASK_CBZ)) begin
            cls     = CLS_CB;
            sign_op = SIGN_CB;
            alu_op  = ALU_PASS_B;
`ifdef MOVZ_EN
        end else if (op_match(opcode, OP_MOVZ, MASK_MOVZ)) begin
            cls     = CLS_IW;
            sign_op = SIGN_IW;
            alu_op  = ALU_PASS_B;
`endif
        end else begin
            cls     = CLS_ILL;
            sign_op = SIGN_I;
            alu_op  = ALU_AND;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 control FSM with sticky illegal-opcode trap and a
// retired-instruction counter. MOVZ_EN enables MOVZ decoding.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             CLK,
    input  logic             Reset,
    input  logic [10:0]      Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic [2:0]       SignOp,
    output logic             Reg2Loc,
    output logic             ALUSrc,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic [3:0]       ALUOp,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstrCount
);

    state_e           state_q, state_d;
    instr_class_e     cls_q, cls_d;
    logic [2:0]       sign_op_q, sign_op_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic             retire_s;

    logic [2:0]       dec_cls_raw_s;
    instr_class_e     dec_cls_s;
    logic [2:0]       dec_sign_s;
    logic [3:0]       dec_alu_s;

    opcode_decode u_decode (
        .opcode  (Opcode),
        .cls     (dec_cls_raw_s),
        .sign_op (dec_sign_s),
        .alu_op  (dec_alu_s)
    );

    assign dec_cls_s = instr_class_e'(dec_cls_raw_s);

    // State and per-instruction registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= ST_FETCH;
            cls_q       <= CLS_R;
            sign_op_q   <= SIGN_I;
            alu_op_q    <= ALU_AND;
            illegal_q   <= 1'b0;
            instr_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            sign_op_q   <= sign_op_d;
            alu_op_q    <= alu_op_d;
            illegal_q   <= illegal_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    // Next-state, class capture and retirement detection.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        sign_op_d = sign_op_q;
        alu_op_d  = alu_op_q;
        illegal_d = illegal_q;
        retire_s  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (MemReady) state_d = ST_DECODE;
                else          state_d = ST_FETCH;
            end
            ST_DECODE: begin
                if (dec_cls_s == CLS_ILL) begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                    sign_op_d = SIGN_I;
                    alu_op_d  = ALU_AND;
                end else begin
                    state_d   = ST_EXEC;
                    cls_d     = dec_cls_s;
                    sign_op_d = dec_sign_s;
                    alu_op_d  = dec_alu_s;
                end
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_B, CLS_CB: begin
                        state_d  = ST_FETCH;
                        retire_s = 1'b1;
                    end
                    CLS_LD, CLS_ST: state_d = ST_MEM;
                    default:        state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (!MemReady) begin
                    state_d = ST_MEM;
                end else if (cls_q == CLS_ST) begin
                    state_d  = ST_FETCH;
                    retire_s = 1'b1;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                state_d  = ST_FETCH;
                retire_s = 1'b1;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
        if (retire_s) instr_cnt_d = instr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        else          instr_cnt_d = instr_cnt_q;
    end

    // Datapath strobes; SignOp shows the live decode in DECODE, then the captured class.
    always_comb begin
        SignOp   = 3'b000;
        ALUOp    = 4'b0000;
        Reg2Loc  = 1'b0;
        ALUSrc   = 1'b0;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        if (Reset) begin
            SignOp = 3'b000;
        end else begin
            SignOp = sign_op_q;
            ALUOp  = alu_op_q;
            case (state_q)
                ST_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                end
                ST_DECODE: begin
                    SignOp  = dec_sign_s;
                    Reg2Loc = (dec_cls_s == CLS_ST) || (dec_cls_s == CLS_CB);
                end
                ST_EXEC: begin
                    Reg2Loc = (cls_q == CLS_ST) || (cls_q == CLS_CB);
                    ALUSrc  = (cls_q == CLS_I) || (cls_q == CLS_LD) ||
                              (cls_q == CLS_ST) || (cls_q == CLS_IW);
                    if (cls_q == CLS_B) begin
                        PCWrite = 1'b1;
                        PCSrc   = 1'b1;
                    end else if (cls_q == CLS_CB) begin
                        PCWrite = 1'b1;
                        PCSrc   = Zero;
                    end else begin
                        PCWrite = 1'b0;
                    end
                end
                ST_MEM: begin
                    MemRead  = (cls_q == CLS_LD);
                    MemWrite = (cls_q == CLS_ST);
                    PCWrite  = (cls_q == CLS_ST) && MemReady;
                end
                ST_WB: begin
                    RegWrite = 1'b1;
                    MemToReg = (cls_q == CLS_LD);
                    PCWrite  = 1'b1;
                end
                ST_TRAP: begin
                    SignOp = 3'b000;
                    ALUOp  = 4'b0000;
                end
                default: begin
                    SignOp = 3'b000;
                end
            endcase
        end
    end

    assign Illegal    = illegal_q;
    assign InstrCount = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (CNT_W=4): per-cycle strobe/SignOp/
// Illegal/InstrCount checks against hand-computed vectors.
module tb_multicycle_control;

    logic        CLK = 1'b0;
    logic        Reset, Zero, MemReady;
    logic [10:0] Opcode;
    logic [2:0]  SignOp;
    logic        Reg2Loc, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite;
    logic        IRWrite, PCWrite, PCSrc, Illegal;
    logic [3:0]  ALUOp;
    logic [3:0]  InstrCount;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic [3:0] exp_cnt;
    logic [8:0] strb;

    localparam logic [8:0] L_R2L = 9'h100, L_ALS = 9'h080, L_M2R = 9'h040;
    localparam logic [8:0] L_RW  = 9'h020, L_MR  = 9'h010, L_MW  = 9'h008;
    localparam logic [8:0] L_IRW = 9'h004, L_PCW = 9'h002, L_PCS = 9'h001;
    localparam logic [8:0] L_NONE = 9'h000;
    localparam logic [3:0] NS = 4'hF;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_ADDI = 11'b10010001001;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_B    = 11'b00010111111;
    localparam logic [10:0] OPC_CBZ  = 11'b10110100101;
    localparam logic [10:0] OPC_MOVZ = 11'b11010010100;
    localparam logic [10:0] OPC_ZERO = 11'b00000000000;

    multicycle_control #(.CNT_W(4)) dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .SignOp(SignOp), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUOp(ALUOp), .Illegal(Illegal),
        .InstrCount(InstrCount)
    );

    always #5 CLK = ~CLK;

    assign strb = {Reg2Loc, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, IRWrite, PCWrite, PCSrc};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check at the falling edge, advance past the rising edge.
    task automatic cyc(input string tag, input logic mr, input logic z, input logic [8:0] es,
                       input logic [3:0] esg, input logic [3:0] ealu, input logic eill);
        Reset = 1'b0; MemReady = mr; Zero = z;
        @(negedge CLK);
        check_val({tag, ".strb"}, {23'd0, strb}, {23'd0, es});
        if (esg != NS)  check_val({tag, ".sign"}, {29'd0, SignOp}, {28'd0, esg});
        if (ealu != NS) check_val({tag, ".alu"}, {28'd0, ALUOp}, {28'd0, ealu});
        check_val({tag, ".ill"}, {31'd0, Illegal}, {31'd0, eill});
        check_val({tag, ".cnt"}, {28'd0, InstrCount}, {28'd0, exp_cnt});
        @(posedge CLK); #1;
    endtask

    task automatic reset_cyc(input string tag);
        Reset = 1'b1; MemReady = 1'b0; Zero = 1'b0;
        @(negedge CLK);
        check_val({tag, ".strb"}, {23'd0, strb}, 32'd0);
        check_val({tag, ".sign"}, {29'd0, SignOp}, 32'd0);
        check_val({tag, ".alu"}, {28'd0, ALUOp}, 32'd0);
        @(posedge CLK); #1;
        Reset = 1'b0;
        exp_cnt = 4'd0;
    endtask

    task automatic run_add(input string tag);
        Opcode = OPC_ADD;
        cyc({tag, ".F"}, 1'b1, 1'b0, L_MR | L_IRW, NS, NS, 1'b0);
        cyc({tag, ".D"}, 1'b1, 1'b0, L_NONE, 4'h0, NS, 1'b0);
        cyc({tag, ".E"}, 1'b1, 1'b0, L_NONE, 4'h0, 4'h2, 1'b0);
        cyc({tag, ".W"}, 1'b1, 1'b0, L_RW | L_PCW, NS, NS, 1'b0);
        exp_cnt = exp_cnt + 4'd1;
    endtask

    initial begin
        Reset = 1'b1; Zero = 1'b0; MemReady = 1'b1; Opcode = OPC_ADD; exp_cnt = 4'd0;
        @(posedge CLK); #1;
        reset_cyc("rst0");

        run_add("add");

        // ADDI with a stalled fetch
        Opcode = OPC_ADDI;
        cyc("addi.F0", 1'b0, 1'b0, L_MR | L_IRW, NS, NS, 1'b0);
        cyc("addi.F1", 1'b1, 1'b0, L_MR | L_IRW, NS, NS, 1'b0);
        cyc("addi.D", 1'b1, 1'b0, L_NONE, 4'h0, NS, 1'b0);
        cyc("addi.E", 1'b1, 1'b0, L_ALS, 4'h0, 4'h2, 1'b0);
        cyc("addi.W", 1'b1, 1'b0, L_RW | L_PCW, NS, NS, 1'b0);
        exp_cnt = exp_cnt + 4'd1;

        // LDUR with three wait cycles in MEM
        Opcode = OPC_LDUR;
        cyc("ld.F", 1'b1, 1'b0, L_MR | L_IRW, NS, NS, 1'b0);
        cyc("ld.D", 1'b1, 1'b0, L_NONE, 4'h1, NS, 1'b0);
        cyc("ld.E", 1'b1, 1'b0, L_ALS, 4'h1, 4'h2, 1'b0);
        for (int i = 0; i < 3; i++) cyc("ld.Mw", 1'b0, 1'b0, L_MR, 4'h1, NS, 1'b0);
        cyc("ld.M", 1'b1, 1'b0, L_MR, 4'h1, NS, 1'b0);
        cyc("ld.W", 1'b1, 1'b0, L_RW | L_M2R | L_PCW, NS, NS, 1'b0);
        exp_cnt = exp_cnt + 4'd1;

        Opcode = OPC_STUR;
        cyc("st.F", 1'b1, 1'b0, L_MR | L_IRW, NS, NS, 1'b0);
        cyc("st.D", 1'b1, 1'b0, L_R2L, 4'h1, NS, 1'b0);
        cyc("st.E", 1'b1, 1'b0, L_R2L | L_ALS, 4'h1, 4'h2, 1'b0);
        cyc("st.M", 1'b1, 1'b0, L_MW | L_PCW, 4'h1, NS, 1'b0);
        exp_cnt = exp_cnt + 4'd1;

        Opcode = OPC_B;
        cyc("b.F", 1'b1, 1'b0, L_MR | L_IRW, NS, NS, 1'b0);
        cyc("b.D", 1'b1, 1'b0, L_NONE, 4'h2, NS, 1'b0);
        cyc("b.E", 1'b1, 1'b0, L_PCW | L_PCS, 4'h2, NS, 1'b0);
        exp_cnt = exp_cnt + 4'd1;

        Opcode = OPC_CBZ;
        cyc("cbz1.F", 1'b1, 1'b1, L_MR | L_IRW, NS, NS, 1'b0);
        cyc("cbz1.D", 1'b1, 1'b1, L_R2L, 4'h3, NS, 1'b0);
        cyc("cbz1.E", 1'b1, 1'b1, L_R2L | L_PCW | L_PCS, 4'h3, NS, 1'b0);
        exp_cnt = exp_cnt + 4'd1;
        cyc("cbz0.F", 1'b1, 1'b0, L_MR | L_IRW, NS, NS, 1'b0);
        cyc("cbz0.D", 1'b1, 1'b0, L_R2L, 4'h3, NS, 1'b0);
        cyc("cbz0.E", 1'b1, 1'b0, L_R2L | L_PCW, 4'h3, NS, 1'b0);
        exp_cnt = exp_cnt + 4'd1;

        Opcode = OPC_MOVZ;
        cyc("movz.F", 1'b1, 1'b0, L_MR | L_IRW, NS, NS, 1'b0);
`ifdef MOVZ_EN
        cyc("movz.D", 1'b1, 1'b0, L_NONE, 4'h4, NS, 1'b0);
        cyc("movz.E", 1'b1, 1'b0, L_ALS, 4'h4, NS, 1'b0);
        cyc("movz.W", 1'b1, 1'b0, L_RW | L_PCW, NS, NS, 1'b0);
        exp_cnt = exp_cnt + 4'd1;
        cyc("movz.next", 1'b1, 1'b0, L_MR | L_IRW, NS, NS, 1'b0);
`else
        cyc("movz.D", 1'b1, 1'b0, L_NONE, 4'h0, NS, 1'b0);
        for (int i = 0; i < 3; i++) cyc("movz.T", 1'b1, 1'b0, L_NONE, 4'h0, NS, 1'b1);
`endif
        reset_cyc("rst1");

        // Undecodable opcode traps until reset
        Opcode = OPC_ZERO;
        cyc("ill.F", 1'b1, 1'b0, L_MR | L_IRW, NS, NS, 1'b0);
        cyc("ill.D", 1'b1, 1'b0, L_NONE, 4'h0, NS, 1'b0);
        for (int i = 0; i < 3; i++) cyc("ill.T", 1'b1, 1'b1, L_NONE, 4'h0, NS, 1'b1);
        reset_cyc("rst2");
        cyc("ill.rF", 1'b0, 1'b0, L_MR | L_IRW, NS, NS, 1'b0);

        // Reset while stalled in MEM returns to FETCH
        Opcode = OPC_LDUR;
        cyc("ldr.F", 1'b1, 1'b0, L_MR | L_IRW, NS, NS, 1'b0);
        cyc("ldr.D", 1'b1, 1'b0, L_NONE, 4'h1, NS, 1'b0);
        cyc("ldr.E", 1'b1, 1'b0, L_ALS, 4'h1, NS, 1'b0);
        cyc("ldr.Mw", 1'b0, 1'b0, L_MR, 4'h1, NS, 1'b0);
        reset_cyc("rst3");
        cyc("ldr.rF", 1'b1, 1'b0, L_MR | L_IRW, NS, NS, 1'b0);
        cyc("ldr.rD", 1'b1, 1'b0, L_NONE, 4'h1, NS, 1'b0);
        cyc("ldr.rE", 1'b1, 1'b0, L_ALS, 4'h1, NS, 1'b0);
        cyc("ldr.rM", 1'b1, 1'b0, L_MR, 4'h1, NS, 1'b0);
        cyc("ldr.rW", 1'b1, 1'b0, L_RW | L_M2R | L_PCW, NS, NS, 1'b0);
        exp_cnt = exp_cnt + 4'd1;

        // Counter wrap: run ADDs up to all ones, then one more
        while (exp_cnt != 4'hF) run_add("fill");
        run_add("wrap");
        @(negedge CLK);
        check_val("wrap.cnt", {28'd0, InstrCount}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
